prils_norm: RTL and testbench



---
 rtl/prils_pkg.sv | 20 ++
 rtl/prils_pe16.sv | 26 ++
 rtl/prils_norm.sv | 149 ++++++++++++++
 tb/tb_prils_norm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prils_pkg.sv
// prils_pkg: shared constants and types for the prils_norm normalizer.
//   WIDTH_DEF / STEP_DEF / LZW_DEF : default datapath, priority-encoder and
//                                    leading-zero-count widths
//   state_t, IDLE/SHIFT/DONE       : 2-bit FSM encoding
//   lzc_t                          : leading-zero count at the default width
package prils_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned STEP_DEF  = 16;
  localparam int unsigned LZW_DEF   = 7;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  typedef logic [LZW_DEF-1:0] lzc_t;

endpackage

// File: rtl/prils_pe16.sv
// prils_pe16: combinational leading-zero priority encoder over STEP bits.
//   bits     in  STEP  slice to examine, bit STEP-1 is the most significant
//   count    out CW    number of leading zeros, 0..STEP (STEP when all zero)
//   all_zero out 1     every bit of the slice is zero
module prils_pe16 #(
  parameter int unsigned STEP = 16,
  parameter int unsigned CW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] bits,
  input  logic            unused_tie,
  output logic [CW-1:0]   count,
  output logic            all_zero
);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(STEP);
    for (int unsigned i = 0; i < STEP; i++) begin
      if (bits[i]) begin
        count = CW'(STEP - 1 - i);
      end
    end
    all_zero = (bits == '0) | (unused_tie & 1'b0);
  end

endmodule

// File: rtl/prils_norm.sv
// prils_norm: iterative mantissa normalizer. Strips leading zeros STEP bits
// per cycle and left-shifts the operand until its MSB is 1.
//   clk      in   1      clock, rising edge
//   reset    in   1      synchronous active-high reset
//   fpuhold  in   1      global stall, freezes all state
//   start    in   1      request to normalize din (accepted in IDLE only)
//   din      in   WIDTH  operand
//   lsdprec  in   1      single precision: only the upper half is examined
//   busy     out  1      high in SHIFT and DONE
//   done     out  1      high in DONE, result valid
//   dout     out  WIDTH  normalized mantissa
//   lzc      out  LZW    total left shift applied
//   zero     out  1      examined operand was all zeros
// Optional build macro PRILS_NORM_MAXSHIFT_EN adds:
//   maxshift in   LZW    upper bound on lzc, captured on start
//   limited  out  1      the bound stopped normalization early
module prils_norm
  import prils_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned STEP  = STEP_DEF,
  parameter int unsigned LZW   = LZW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fpuhold,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             lsdprec,
`ifdef PRILS_NORM_MAXSHIFT_EN
  input  logic [LZW-1:0]   maxshift,
  output logic             limited,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [LZW-1:0]   lzc,
  output logic             zero
);

  localparam int unsigned CW = $clog2(STEP + 1);
  localparam logic [WIDTH-1:0] HI_MASK = {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};
  localparam logic [LZW-1:0] LZ_FULL = LZW'(WIDTH);
  localparam logic [LZW-1:0] LZ_HALF = LZW'(WIDTH / 2);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [LZW-1:0]   acc;

  logic [WIDTH-1:0] captured;
  logic             captured_zero;
  logic [CW-1:0]    pe_count;
  logic             pe_zero;
  logic [LZW-1:0]   step_amt;
  logic [LZW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;
  logic             finish_shift;

  // Single precision never needs the captured flag later: the masked lower
  // half is zero and the upper half is nonzero, so lzc stays <= WIDTH/2.
  assign captured      = lsdprec ? (din & HI_MASK) : din;
  assign captured_zero = (captured == '0);

  prils_pe16 #(
    .STEP (STEP),
    .CW   (CW)
  ) u_pe (
    .bits       (work[WIDTH-1 -: STEP]),
    .unused_tie (1'b0),
    .count      (pe_count),
    .all_zero   (pe_zero)
  );

  assign step_amt = pe_zero ? LZW'(STEP) : LZW'(pe_count);

`ifdef PRILS_NORM_MAXSHIFT_EN
  logic [LZW-1:0] max_q;
  logic [LZW-1:0] room;
  logic           clamp;

  // An all-zero window that exactly uses up the remaining room also ends the
  // operation, since no further shift would be allowed.
  always_comb begin
    room         = max_q - acc;
    clamp        = pe_zero ? (step_amt >= room) : (step_amt > room);
    shamt        = clamp ? room : step_amt;
    finish_shift = ~pe_zero | clamp;
  end
`else
  always_comb begin
    shamt        = step_amt;
    finish_shift = ~pe_zero;
  end
`endif

  assign shifted = work << shamt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      acc   <= '0;
      zero  <= 1'b0;
`ifdef PRILS_NORM_MAXSHIFT_EN
      max_q   <= '0;
      limited <= 1'b0;
`endif
    end else if (!fpuhold) begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= captured;
            zero  <= captured_zero;
            acc   <= captured_zero ? (lsdprec ? LZ_HALF : LZ_FULL) : '0;
            state <= captured_zero ? DONE : SHIFT;
`ifdef PRILS_NORM_MAXSHIFT_EN
            max_q   <= maxshift;
            limited <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          work <= shifted;
          acc  <= acc + shamt;
          if (finish_shift) begin
            state <= DONE;
          end
`ifdef PRILS_NORM_MAXSHIFT_EN
          if (clamp) begin
            limited <= ~shifted[WIDTH-1];
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);
  assign dout = work;
  assign lzc  = acc;

endmodule

// File: tb/tb_prils_norm.sv
// tb_prils_norm: directed self-checking bench for prils_norm (default build).
// A transaction-level model predicts busy/done timing and the final
// dout/lzc/zero; a compare process checks them every cycle, and the driver
// pins hand-computed latencies and results for the directed vectors.
module tb_prils_norm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fpuhold = 1'b0;
  logic        start = 1'b0;
  logic        lsdprec = 1'b0;
  logic [63:0] din = '0;
  logic        busy, done, zero;
  logic [63:0] dout;
  logic [6:0]  lzc;

  prils_norm #(
    .WIDTH (64),
    .STEP  (16),
    .LZW   (7)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fpuhold (fpuhold),
    .start   (start),
    .din     (din),
    .lsdprec (lsdprec),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .lzc     (lzc),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Result of normalizing one operand, straight from the arithmetic rules.
  function automatic void norm_model(input logic [63:0] d, input logic sp,
                                     output logic [63:0] o, output int lz,
                                     output bit z, output int k);
    logic [63:0] op;
    int l;
    op = sp ? {d[63:32], 32'h0} : d;
    if (op == 64'h0) begin
      o = 64'h0; z = 1'b1; lz = sp ? 32 : 64; k = 0;
    end else begin
      l = 0;
      while (op[63 - l] == 1'b0) l++;
      o = op << l; z = 1'b0; lz = l; k = l / 16 + 1;
    end
  endfunction

  // Model: cycles of SHIFT still to run, whether DONE is showing, final results.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_dout = '0;
  int          m_lzc  = 0;
  bit          m_zero = 1'b0;

  initial begin
    logic [63:0] t_o;
    int t_lz, t_k;
    bit t_z;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_left = 0; m_done = 1'b0; m_dout = '0; m_lzc = 0; m_zero = 1'b0;
      end else if (!fpuhold) begin
        if (m_done) begin
          m_done = 1'b0;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end else if (start) begin
          norm_model(din, lsdprec, t_o, t_lz, t_z, t_k);
          m_dout = t_o; m_lzc = t_lz; m_zero = t_z;
          if (t_k == 0) m_done = 1'b1;
          else m_left = t_k;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("cmp_busy", 64'(busy), 64'(m_done || (m_left > 0)));
        check("cmp_done", 64'(done), 64'(m_done));
        if (m_left == 0) begin
          check("cmp_dout", dout, m_dout);
          check("cmp_lzc", 64'(lzc), 64'(m_lzc));
          check("cmp_zero", 64'(zero), 64'(m_zero));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] d, input logic sp, output int n);
    din = d; lsdprec = sp; start = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int exp_lat, input string name);
    for (int i = 0; i < 40 && !done; i++) tick();
    if (!done) check({name, "_timeout"}, 64'(done), 64'd1);
    else check({name, "_latency"}, 64'(cyc - n), 64'(exp_lat));
  endtask

  task automatic run_vec(input string name, input logic [63:0] d, input logic sp,
                         input int lat, input logic [63:0] e_dout,
                         input int e_lzc, input bit e_zero);
    int n;
    launch(d, sp, n);
    wait_done(n, lat, name);
    check({name, "_dout"}, dout, e_dout);
    check({name, "_lzc"}, 64'(lzc), 64'(e_lzc));
    check({name, "_zero"}, 64'(zero), 64'(e_zero));
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    armed = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_lzc", 64'(lzc), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    tick();

    run_vec("msb_set", 64'h8000_0000_0000_0000, 1'b0, 2, 64'h8000_0000_0000_0000, 0, 1'b0);
    run_vec("lz47", 64'h0000_0000_0001_0000, 1'b0, 4, 64'h8000_0000_0000_0000, 47, 1'b0);
    run_vec("zero_dp", 64'h0, 1'b0, 1, 64'h0, 64, 1'b1);
    run_vec("zero_sp", 64'h0, 1'b1, 1, 64'h0, 32, 1'b1);
    run_vec("sp_lz31", 64'h0000_0001_FFFF_FFFF, 1'b1, 3, 64'h8000_0000_0000_0000, 31, 1'b0);
    run_vec("sp_mask", 64'h8000_0000_FFFF_FFFF, 1'b1, 2, 64'h8000_0000_0000_0000, 0, 1'b0);
    run_vec("sp_lower_only", 64'h0000_0000_FFFF_FFFF, 1'b1, 1, 64'h0, 32, 1'b1);
    run_vec("lz63", 64'h0000_0000_0000_0001, 1'b0, 5, 64'h8000_0000_0000_0000, 63, 1'b0);
    run_vec("lz8", 64'h00F0_0000_1234_5678, 1'b0, 2, 64'hF000_0012_3456_7800, 8, 1'b0);
    run_vec("lz15", 64'h0001_0000_0000_0003, 1'b0, 2, 64'h8000_0000_0001_8000, 15, 1'b0);
    run_vec("lz16", 64'h0000_8000_0000_0001, 1'b0, 3, 64'h8000_0000_0001_0000, 16, 1'b0);

    // fpuhold for three SHIFT cycles plus a start pulse while busy.
    launch(64'h0000_0000_0001_0000, 1'b0, n);
    din = 64'h8000_0000_0000_0000; start = 1'b1;
    tick();
    start = 1'b0; fpuhold = 1'b1;
    tick();
    tick();
    tick();
    fpuhold = 1'b0;
    wait_done(n, 7, "hold");
    check("hold_lzc", 64'(lzc), 64'd47);
    check("hold_dout", dout, 64'h8000_0000_0000_0000);
    fpuhold = 1'b1;
    tick();
    check("hold_done1", 64'(done), 64'd1);
    tick();
    check("hold_done2", 64'(done), 64'd1);
    fpuhold = 1'b0;
    tick();
    check("hold_idle_busy", 64'(busy), 64'd0);
    tick();
    check("no_queue_busy", 64'(busy), 64'd0);
    check("idle_keep_lzc", 64'(lzc), 64'd47);

    // Reset in the middle of an operation, then an immediate new start.
    launch(64'h0000_0000_0001_0000, 1'b0, n);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_lzc", 64'(lzc), 64'd0);
    run_vec("after_rst", 64'h0000_4000_0000_0000, 1'b0, 3, 64'h8000_0000_0000_0000, 17, 1'b0);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
